// File: rtl/floppy_period_gen.sv
// floppy_period_gen
//   Converts per-channel MIDI note requests into stepper half-periods (in clk
//   cycles) for floppy-drive music. One shared conversion engine serves the
//   channels round-robin: the note is octave-reduced into the base table range
//   (MIDI 21..32), counting octaves k, then the base half-period is divided by
//   2^k with round-half-up.
//
//   Optional feature: define FLOPPY_FOLD_EN to fold notes above MAX_NOTE down
//   by octaves. Without it such notes produce the silent code 22'h3FFFFF.
//
// Handshake: req[i] is a one-cycle strobe. The note on note[7i+6:7i] is
//   latched in that same cycle, and the latest strobe before service wins.
//   done[i] pulses for one cycle in the cycle that setpoint[i] takes its new
//   value. There is no back-pressure; requests never stall.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req        per-channel note-update strobe
//   note       per-channel MIDI note, channel i at [7i+6:7i]
//   setpoint   per-channel half-period, channel i at [22i+21:22i]
//   done       per-channel update pulse
//   busy       conversion engine not idle
//   dbg_state  current FSM state (IDLE=0, REDUCE=1, OUT=2)
module floppy_period_gen #(
   parameter int CHANNELS = 4,
   parameter int MAX_NOTE = 69
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHANNELS-1:0]      req,
   input  logic [7*CHANNELS-1:0]    note,
   output logic [22*CHANNELS-1:0]   setpoint,
   output logic [CHANNELS-1:0]      done,
   output logic                     busy,
   output logic [1:0]               dbg_state
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, REDUCE = 2'd1, OUT = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [6:0]              n_q, n_d;
   logic [3:0]              k_q, k_d;
   logic                    invalid_q, invalid_d;
   logic [CW-1:0]           ch_q, ch_d;
   logic [CW-1:0]           ptr_q, ptr_d;
   logic [CHANNELS-1:0]     pending_q, pending_d;
   logic [7*CHANNELS-1:0]   latched_q, latched_d;
   logic [22*CHANNELS-1:0]  setpoint_q, setpoint_d;
   logic [CHANNELS-1:0]     done_q, done_d;

   // Request view that includes this cycle's strobes, so an idle engine can
   // accept a channel in the same edge its req arrives.
   logic [CHANNELS-1:0]     eff_pend;
   logic [7*CHANNELS-1:0]   eff_note;
   logic                    found;
   logic [CW-1:0]           sel;
   logic [CW:0]             cand;

   logic [21:0]             base_val;
   logic [22:0]             rnd;
   logic [22:0]             sum;
   logic [21:0]             conv;

   function automatic logic [21:0] base_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    base_lut = 22'd909091;
         4'd1:    base_lut = 22'd858068;
         4'd2:    base_lut = 22'd809908;
         4'd3:    base_lut = 22'd764451;
         4'd4:    base_lut = 22'd721546;
         4'd5:    base_lut = 22'd681049;
         4'd6:    base_lut = 22'd642824;
         4'd7:    base_lut = 22'd606745;
         4'd8:    base_lut = 22'd572691;
         4'd9:    base_lut = 22'd540549;
         4'd10:   base_lut = 22'd510210;
         4'd11:   base_lut = 22'd481574;
         default: base_lut = 22'd0;
      endcase
   endfunction

   // Octave division with round-half-up; 23 bits keeps the +2^(k-1) term
   // from overflowing for any k up to 8.
   always_comb begin
      base_val = base_lut(4'(n_q - 7'd21));
      rnd      = (k_q == 4'd0) ? 23'd0 : (23'd1 << (k_q - 4'd1));
      sum      = {1'b0, base_val} + rnd;
      conv     = 22'(sum >> k_q);
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      k_d        = k_q;
      invalid_d  = invalid_q;
      ch_d       = ch_q;
      ptr_d      = ptr_q;
      setpoint_d = setpoint_q;
      done_d     = '0;
      found      = 1'b0;
      sel        = '0;
      cand       = '0;
      eff_note   = latched_q;

      for (int i = 0; i < CHANNELS; i++) begin
         if (req[i]) eff_note[7*i +: 7] = note[7*i +: 7];
      end
      eff_pend  = pending_q | req;
      latched_d = eff_note;
      pending_d = eff_pend;

      // Round-robin search starting at the channel after the last one served.
      for (int i = 0; i < CHANNELS; i++) begin
         cand = {1'b0, ptr_q} + (CW+1)'(i);
         if (cand >= (CW+1)'(CHANNELS)) cand = cand - (CW+1)'(CHANNELS);
         if (!found && eff_pend[cand[CW-1:0]]) begin
            found = 1'b1;
            sel   = cand[CW-1:0];
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               pending_d[sel] = 1'b0;
               ch_d           = sel;
               ptr_d          = (int'(sel) == CHANNELS - 1) ? '0 : sel + CW'(1);
               k_d            = 4'd0;
               n_d            = eff_note[7*int'(sel) +: 7];
               if (eff_note[7*int'(sel) +: 7] < 7'd21) begin
                  invalid_d = 1'b1;
                  state_d   = OUT;
               end else begin
                  invalid_d = 1'b0;
                  state_d   = REDUCE;
               end
            end
         end
         REDUCE: begin
            if (int'(n_q) > MAX_NOTE) begin
`ifdef FLOPPY_FOLD_EN
               n_d = n_q - 7'd12;
`else
               invalid_d = 1'b1;
               state_d   = OUT;
`endif
            end else if (n_q >= 7'd33) begin
               n_d = n_q - 7'd12;
               k_d = k_q + 4'd1;
            end else begin
               state_d = OUT;
            end
         end
         OUT: begin
            setpoint_d[22*int'(ch_q) +: 22] = invalid_q ? 22'h3FFFFF : conv;
            done_d[ch_q] = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         k_q        <= '0;
         invalid_q  <= 1'b0;
         ch_q       <= '0;
         ptr_q      <= '0;
         pending_q  <= '0;
         latched_q  <= '0;
         setpoint_q <= '1;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         k_q        <= k_d;
         invalid_q  <= invalid_d;
         ch_q       <= ch_d;
         ptr_q      <= ptr_d;
         pending_q  <= pending_d;
         latched_q  <= latched_d;
         setpoint_q <= setpoint_d;
         done_q     <= done_d;
      end
   end

   assign setpoint  = setpoint_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule
